// File: rtl/tl_pkg.sv
// Shared transaction-layer types and helpers.
// Used by the transmit VC arbiter and the round-robin picker.
package tl_pkg;

    localparam int NUM_VC        = 4;
    localparam int VC_IDX_W      = 2;
    localparam int DEF_LINE_SIZE = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    // Rotating first-one search: returns {hit, idx}, scanning from ptr upward with wrap.
    function automatic logic [VC_IDX_W:0] rr_first(
        input logic [NUM_VC-1:0]   req,
        input logic [VC_IDX_W-1:0] ptr
    );
        logic [VC_IDX_W:0]   r;
        logic [VC_IDX_W-1:0] i;
        r = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            i = ptr + VC_IDX_W'(k);
            if (req[i]) begin
                r = {1'b1, i};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tl_vc_arbiter_if.sv
// Bundle between the four class FIFOs, the arbiter and the outbound FIFO.
// master = arbiter side, slave = FIFO/environment side.
interface tl_vc_arbiter_if
    import tl_pkg::*;
#(
    parameter int LINE_SIZE = DEF_LINE_SIZE
);

    logic [NUM_VC-1:0]           empty_in;
    logic [NUM_VC*LINE_SIZE-1:0] data_in;
    logic                        almost_full_in;
    logic [NUM_VC-1:0]           pop_out;
    logic                        push_out;
    logic [LINE_SIZE-1:0]        data_out;
    logic [VC_IDX_W-1:0]         grant_out;

    modport master (
        input  empty_in,
        input  data_in,
        input  almost_full_in,
        output pop_out,
        output push_out,
        output data_out,
        output grant_out
    );

    modport slave (
        output empty_in,
        output data_in,
        output almost_full_in,
        input  pop_out,
        input  push_out,
        input  data_out,
        input  grant_out
    );

endinterface

// File: rtl/tl_rr_pick.sv
// Combinational rotating first-one picker over four requesters.
// Shared with the receive-side credit arbiter.
module tl_rr_pick
    import tl_pkg::*;
(
    input  logic [NUM_VC-1:0]   req,
    input  logic [VC_IDX_W-1:0] ptr,
    output logic                hit,
    output logic [VC_IDX_W-1:0] idx
);

    assign {hit, idx} = rr_first(req, ptr);

endmodule

// File: rtl/tl_vc_arbiter.sv
// Transmit merge: drains four class FIFOs into one outbound FIFO with burst-limited RR.
// Define TL_VC_ARB_STRICT_PRIO_EN for fixed priority (VC0 highest) instead of round-robin.
module tl_vc_arbiter
    import tl_pkg::*;
#(
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int BURST     = 4
)(
    input  logic            clk,
    input  logic            reset,
    tl_vc_arbiter_if.master bus
);

    arb_state_e            state;
    logic [VC_IDX_W-1:0]   grant;
    logic [3:0]            burst_cnt;
    logic                  valid_q;
    logic [VC_IDX_W-1:0]   idx_q;
    logic [LINE_SIZE-1:0]  data_q;
    logic [LINE_SIZE-1:0]  rd_word;
    logic [NUM_VC-1:0]     pop;
    logic                  pick_hit;
    logic [VC_IDX_W-1:0]   pick_idx;
    logic [VC_IDX_W-1:0]   pick_ptr;
    logic                  last_pop;

`ifdef TL_VC_ARB_STRICT_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [VC_IDX_W-1:0]   rr_ptr;
    assign pick_ptr = rr_ptr;
`endif

    tl_rr_pick u_pick (
        .req (~bus.empty_in),
        .ptr (pick_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // Pop the granted class only when it has data and the outbound side has room.
    always_comb begin
        pop = '0;
        if (state == SERVE && !bus.empty_in[grant] && !bus.almost_full_in) begin
            pop[grant] = 1'b1;
        end
    end

    assign last_pop = (burst_cnt == 4'(BURST - 1));

    // Select the read data of the class popped last cycle.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (idx_q == VC_IDX_W'(i)) begin
                rd_word = bus.data_in[i*LINE_SIZE +: LINE_SIZE];
            end
        end
    end

    // Arbitration FSM, burst counter and one-stage read pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            burst_cnt <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
`ifndef TL_VC_ARB_STRICT_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            valid_q <= |pop;
            idx_q   <= grant;
            if (valid_q) begin
                data_q <= rd_word;
            end
            unique case (state)
                IDLE: begin
                    if (pick_hit) begin
                        grant     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (bus.empty_in[grant]) begin
`ifndef TL_VC_ARB_STRICT_PRIO_EN
                        rr_ptr <= grant + 2'd1;
`endif
                        state  <= IDLE;
                    end else if (|pop) begin
                        burst_cnt <= burst_cnt + 4'd1;
                        if (last_pop) begin
`ifndef TL_VC_ARB_STRICT_PRIO_EN
                            rr_ptr <= grant + 2'd1;
`endif
                            state  <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // The pushed word bypasses the holding register so push and data align.
    assign bus.pop_out   = pop;
    assign bus.push_out  = valid_q;
    assign bus.data_out  = valid_q ? rd_word : data_q;
    assign bus.grant_out = grant;

endmodule

// File: tb/tb_tl_vc_arbiter.sv
// Scoreboard bench for tl_vc_arbiter: FIFO models feed the DUT, a monitor checks pushes.
// Directed scenarios plus a random empty/almost_full soak.
module tb_tl_vc_arbiter;
    import tl_pkg::*;

    localparam int LS    = 12;
    localparam int BURST = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tl_vc_arbiter_if #(.LINE_SIZE(LS)) bus ();

    tl_vc_arbiter #(.LINE_SIZE(LS), .BURST(BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [LS-1:0] fq [4][$];
    logic [LS-1:0] epc [4][$];
    logic [LS-1:0] exp_q [$];
    logic [LS-1:0] rd_data [4];
    logic [3:0]    emask   = '0;
    logic [3:0]    empty_v = 4'hF;
    logic [3:0]    pop_s   = '0;
    logic          af      = 1'b0;
    bit            rmode   = 1'b0;
    int            n_chk   = 0;
    int            n_fail  = 0;
    int            n_push  = 0;
    logic [1:0]    mcls;

    assign bus.empty_in       = empty_v;
    assign bus.almost_full_in = af;
    assign bus.data_in        = {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Class FIFO models: read data appears the cycle after a pop.
    initial for (int i = 0; i < 4; i++) rd_data[i] = '0;
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i] && fq[i].size() != 0) rd_data[i] = fq[i].pop_front();
            empty_v[i] = (fq[i].size() == 0) || emask[i];
        end
    end

    // Monitor: invariants every cycle, pushed words against the scoreboard.
    always @(negedge clk) begin
        pop_s = bus.pop_out;
        chk("pop_onehot", 32'($onehot0(bus.pop_out)), 1);
        chk("pop_on_empty", 32'(|(bus.pop_out & bus.empty_in)), 0);
        chk("pop_on_af", 32'(af && (|bus.pop_out)), 0);
        if (bus.push_out) begin
            n_push++;
            if (rmode) begin
                mcls = bus.data_out[LS-1:LS-2];
                if (epc[mcls].size() == 0) chk("push_unexpected", 1, 0);
                else chk("data_vc", bus.data_out, epc[mcls].pop_front());
            end else begin
                if (exp_q.size() == 0) chk("push_unexpected", 1, 0);
                else chk("data", bus.data_out, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    function automatic bit drained();
        bit d;
        d = (exp_q.size() == 0);
        for (int i = 0; i < 4; i++) begin
            if (fq[i].size() != 0 || epc[i].size() != 0) d = 1'b0;
        end
        return d;
    endfunction

    task automatic wait_idle(input int maxc);
        int quiet;
        quiet = 0;
        for (int c = 0; c < maxc && quiet < 3; c++) begin
            @(negedge clk);
            if (drained() && !bus.push_out && bus.pop_out == 4'b0) quiet++;
            else quiet = 0;
        end
        chk("drain_timeout", 32'(quiet >= 3), 1);
        cyc();
    endtask

    function automatic logic [LS-1:0] tag(input int v, input int s);
        return {2'(v), 10'(s)};
    endfunction

    initial begin
        int n0;
        int np;
        logic [9:0] seq [4];
        int v;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_pop", bus.pop_out, 0);
        chk("rst_push", bus.push_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_grant", bus.grant_out, 0);

        // Single class VC2, three words
        cyc();
        n0 = n_push;
        fq[2].push_back(12'hDE4); fq[2].push_back(12'h96C); fq[2].push_back(12'h16E);
        exp_q.push_back(12'hDE4); exp_q.push_back(12'h96C); exp_q.push_back(12'h16E);
        @(negedge clk);
        chk("t1_bubble", bus.pop_out, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_pop", bus.pop_out, 4'b0100);
        end
        @(negedge clk);
        chk("t1_stop", bus.pop_out, 0);
        wait_idle(50);
        chk("t1_npush", n_push - n0, 3);

        // All four classes, six words each, burst of 4
        do_reset();
        n0 = n_push;
        for (int i = 0; i < 4; i++)
            for (int s = 0; s < 6; s++) fq[i].push_back(tag(i, s));
`ifdef TL_VC_ARB_STRICT_PRIO_EN
        for (int i = 0; i < 4; i++)
            for (int s = 0; s < 6; s++) exp_q.push_back(tag(i, s));
`else
        for (int i = 0; i < 4; i++)
            for (int s = 0; s < 4; s++) exp_q.push_back(tag(i, s));
        for (int i = 0; i < 4; i++)
            for (int s = 4; s < 6; s++) exp_q.push_back(tag(i, s));
`endif
        wait_idle(300);
        chk("t2_npush", n_push - n0, 24);

        // almost_full stall on VC1 after two pops
        do_reset();
        n0 = n_push;
        for (int s = 0; s < 6; s++) begin
            fq[1].push_back(tag(1, s));
            exp_q.push_back(tag(1, s));
        end
        np = 0;
        for (int c = 0; c < 20 && np < 2; c++) begin
            @(negedge clk);
            if (bus.pop_out[1]) np++;
        end
        chk("t3_two_pops", np, 2);
        cyc();
        af = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_af_pop", bus.pop_out, 0);
            chk("t3_af_push", bus.push_out, (k == 0) ? 1 : 0);
            chk("t3_af_grant", bus.grant_out, 1);
            if (k < 4) cyc();
        end
        cyc();
        af = 1'b0;
        @(negedge clk);
        chk("t3_resume0", bus.pop_out, 4'b0010);
        @(negedge clk);
        chk("t3_resume1", bus.pop_out, 4'b0010);
        @(negedge clk);
        chk("t3_burst_end", bus.pop_out, 0);
        wait_idle(50);
        chk("t3_npush", n_push - n0, 6);

        // Reset right after a pop drops the in-flight word
        do_reset();
        fq[0].push_back(12'hA01); fq[0].push_back(12'hA02); fq[0].push_back(12'hA03);
        exp_q.push_back(12'hA02); exp_q.push_back(12'hA03);
        np = 0;
        for (int c = 0; c < 20 && np < 1; c++) begin
            @(negedge clk);
            if (bus.pop_out[0]) np++;
        end
        chk("t4_pop_seen", np, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("t4_push", bus.push_out, 0);
        chk("t4_grant", bus.grant_out, 0);
        chk("t4_data", bus.data_out, 0);
        chk("t4_nopop", bus.pop_out, 0);
        @(negedge clk);
        chk("t4_rearb", bus.pop_out, 4'b0001);
        wait_idle(50);

        // rr_ptr at 3, VC3 and VC0 both pending
        do_reset();
        fq[2].push_back(12'h2AA);
        exp_q.push_back(12'h2AA);
        wait_idle(50);
        fq[3].push_back(12'hC33);
        fq[0].push_back(12'h011);
`ifdef TL_VC_ARB_STRICT_PRIO_EN
        exp_q.push_back(12'h011); exp_q.push_back(12'hC33);
`else
        exp_q.push_back(12'hC33); exp_q.push_back(12'h011);
`endif
        @(negedge clk);
        chk("t5_bubble", bus.pop_out, 0);
        @(negedge clk);
`ifdef TL_VC_ARB_STRICT_PRIO_EN
        chk("t5_first", bus.pop_out, 4'b0001);
        chk("t5_grant", bus.grant_out, 0);
`else
        chk("t5_first", bus.pop_out, 4'b1000);
        chk("t5_grant", bus.grant_out, 3);
`endif
        wait_idle(50);

        // Random empty / almost_full soak, per-class order via tags
        rmode = 1'b1;
        for (int i = 0; i < 4; i++) seq[i] = '0;
        for (int c = 0; c < 10000; c++) begin
            cyc();
            af = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) emask[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                v = int'($urandom_range(0, 3));
                if (fq[v].size() < 8) begin
                    fq[v].push_back({2'(v), seq[v]});
                    epc[v].push_back({2'(v), seq[v]});
                    seq[v] = seq[v] + 10'd1;
                end
            end
        end
        cyc();
        af = 1'b0;
        emask = '0;
        wait_idle(500);
        for (int i = 0; i < 4; i++) chk("rand_left", epc[i].size(), 0);
        rmode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
